// File: rtl/riscv_pipeline_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_pipeline_core: 3-stage (F / D / M) RV32I-subset core with internal |
// | memories. Macro RISCV_FORWARDING_EN: M->D forwarding instead of stalls.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module riscv_reg_file #(
  parameter int DW                  = 32,
  parameter int REGW                = 5,
  parameter int NO_OF_REGS_REG_FILE = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [REGW-1:0] rd_i,
  input  logic [DW-1:0]   wd_i,
  input  logic [REGW-1:0] rs1_i,
  input  logic [REGW-1:0] rs2_i,
  output logic [DW-1:0]   rs1_data_o,
  output logic [DW-1:0]   rs2_data_o
);
  logic [DW-1:0] reg_file [NO_OF_REGS_REG_FILE];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NO_OF_REGS_REG_FILE; i++) begin
        reg_file[i] <= '0;
      end
    end else if (we_i && (rd_i != '0)) begin
      reg_file[rd_i] <= wd_i;
    end
  end

  assign rs1_data_o = (rs1_i == '0) ? '0 : reg_file[rs1_i];
  assign rs2_data_o = (rs2_i == '0) ? '0 : reg_file[rs2_i];
endmodule

module riscv_data_mem #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int NO_OF_REGS = 256
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wd_i,
  output logic [DW-1:0] rd_o
);
  logic [DW-1:0] data_mem [NO_OF_REGS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_mem[addr_i] <= wd_i;
    end
  end

  assign rd_o = data_mem[addr_i];
endmodule

module riscv_pipeline_core #(
  parameter int DW                  = 32,
  parameter int REG_SIZE            = 32,
  parameter int NO_OF_REGS_REG_FILE = 32,
  parameter int REGW                = $clog2(REG_SIZE),
  parameter int MEM_SIZE_IN_KB      = 1,
  parameter int NO_OF_REGS          = MEM_SIZE_IN_KB * 1024 / 4,
  parameter int ADDENT              = 4
) (
  input logic clk_i,
  input logic rst_i
);
  localparam int AW = $clog2(NO_OF_REGS);
  localparam logic [DW-1:0] C_NOP = DW'(32'h0000_0013);

`ifdef RISCV_FORWARDING_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  // Program image; contents are loaded before reset is released.
  logic [DW-1:0] instr_mem [NO_OF_REGS];
  initial begin
    for (int i = 0; i < NO_OF_REGS; i++) begin
      instr_mem[i] = C_NOP;
    end
  end

  logic [DW-1:0]   pc_f;
  logic [DW-1:0]   instr_f;
  logic [DW-1:0]   pc_d;
  logic [DW-1:0]   instr_d;

  logic [DW-1:0]   alu_m;
  logic [DW-1:0]   rs2_data_m;
  logic [DW-1:0]   link_m;
  logic [REGW-1:0] rd_m;
  logic            reg_write_m;
  logic            mem_write_m;
  logic [1:0]      res_sel_m;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [REGW-1:0] rd_d;
  logic [REGW-1:0] rs1_d;
  logic [REGW-1:0] rs2_d;
  logic [DW-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [3:0]      alu_base;
  logic [3:0]      alu_op;
  logic [1:0]      sel_a;
  logic            b_imm;
  logic [DW-1:0]   imm;
  logic            reg_write;
  logic            mem_write;
  logic [1:0]      res_sel;
  logic            is_branch, is_jal, is_jalr;
  logic            use_rs1, use_rs2;

  logic [DW-1:0]   rf_rs1, rf_rs2;
  logic [DW-1:0]   rs1_v, rs2_v;
  logic [DW-1:0]   alu_a, alu_b, alu_y;
  logic [DW-1:0]   load_data;
  logic [DW-1:0]   wb_m;
  logic            forward_a, forward_b;
  logic            hazard, stall;
  logic            br_cond, take;
  logic [DW-1:0]   jalr_sum, target;

  assign instr_f = instr_mem[pc_f[AW+1:2]];

  assign opcode = instr_d[6:0];
  assign rd_d   = instr_d[11:7];
  assign funct3 = instr_d[14:12];
  assign rs1_d  = instr_d[19:15];
  assign rs2_d  = instr_d[24:20];
  assign funct7 = instr_d[31:25];

  assign imm_i = {{20{instr_d[31]}}, instr_d[31:20]};
  assign imm_s = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
  assign imm_b = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
  assign imm_u = {instr_d[31:12], 12'b0};
  assign imm_j = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};

  always_comb begin
    case (funct3)
      3'd1:    alu_base = ALU_SLL;
      3'd2:    alu_base = ALU_SLT;
      3'd3:    alu_base = ALU_SLTU;
      3'd4:    alu_base = ALU_XOR;
      3'd5:    alu_base = ALU_SRL;
      3'd6:    alu_base = ALU_OR;
      3'd7:    alu_base = ALU_AND;
      default: alu_base = ALU_ADD;
    endcase
  end

  // Anything not recognised leaves every write enable low and so behaves as a NOP.
  always_comb begin
    alu_op    = ALU_ADD;
    sel_a     = A_RS1;
    b_imm     = 1'b1;
    imm       = imm_i;
    reg_write = 1'b0;
    mem_write = 1'b0;
    res_sel   = RES_ALU;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        b_imm   = 1'b0;
        if (funct7 == 7'h00) begin
          alu_op    = alu_base;
          reg_write = 1'b1;
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          alu_op    = ALU_SUB;
          reg_write = 1'b1;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          alu_op    = ALU_SRA;
          reg_write = 1'b1;
        end
      end
      OPC_OPIMM: begin
        use_rs1 = 1'b1;
        alu_op  = alu_base;
        if (funct3 == 3'd1) begin
          reg_write = (funct7 == 7'h00);
        end else if (funct3 == 3'd5) begin
          if (funct7 == 7'h20) alu_op = ALU_SRA;
          reg_write = (funct7 == 7'h00) || (funct7 == 7'h20);
        end else begin
          reg_write = 1'b1;
        end
      end
      OPC_LOAD: begin
        use_rs1   = 1'b1;
        reg_write = (funct3 == 3'd2);
        res_sel   = RES_MEM;
      end
      OPC_STORE: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        imm       = imm_s;
        mem_write = (funct3 == 3'd2);
      end
      OPC_LUI: begin
        sel_a     = A_ZERO;
        imm       = imm_u;
        reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        sel_a     = A_PC;
        imm       = imm_u;
        reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        is_branch = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      OPC_JAL: begin
        is_jal    = 1'b1;
        reg_write = 1'b1;
        res_sel   = RES_PC4;
      end
      OPC_JALR: begin
        use_rs1   = 1'b1;
        is_jalr   = (funct3 == 3'd0);
        reg_write = (funct3 == 3'd0);
        res_sel   = RES_PC4;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (res_sel_m)
      RES_MEM: wb_m = load_data;
      RES_PC4: wb_m = link_m;
      default: wb_m = alu_m;
    endcase
  end

  assign forward_a = FWD_EN && reg_write_m && (rd_m != '0) && (rd_m == rs1_d);
  assign forward_b = FWD_EN && reg_write_m && (rd_m != '0) && (rd_m == rs2_d);
  assign hazard    = reg_write_m && (rd_m != '0) &&
                     ((use_rs1 && (rd_m == rs1_d)) || (use_rs2 && (rd_m == rs2_d)));
  assign stall     = !FWD_EN && hazard;

  assign rs1_v = forward_a ? wb_m : rf_rs1;
  assign rs2_v = forward_b ? wb_m : rf_rs2;

  always_comb begin
    case (sel_a)
      A_PC:    alu_a = pc_d;
      A_ZERO:  alu_a = '0;
      default: alu_a = rs1_v;
    endcase
    alu_b = b_imm ? imm : rs2_v;
  end

  always_comb begin
    case (alu_op)
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SLL:  alu_y = alu_a << alu_b[4:0];
      ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_y = $signed(alu_a) >>> alu_b[4:0];
      ALU_SLT:  alu_y = {{(DW-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {{(DW-1){1'b0}}, alu_a < alu_b};
      default:  alu_y = alu_a + alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'd0:    br_cond = (rs1_v == rs2_v);
      3'd1:    br_cond = (rs1_v != rs2_v);
      3'd4:    br_cond = ($signed(rs1_v) < $signed(rs2_v));
      3'd5:    br_cond = ($signed(rs1_v) >= $signed(rs2_v));
      3'd6:    br_cond = (rs1_v < rs2_v);
      3'd7:    br_cond = (rs1_v >= rs2_v);
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr_sum = rs1_v + imm_i;
  assign target   = is_jalr ? {jalr_sum[DW-1:1], 1'b0} : (pc_d + (is_jal ? imm_j : imm_b));
  // A stalled instruction still has stale operands, so it must not redirect.
  assign take     = (is_jal || is_jalr || (is_branch && br_cond)) && !stall;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_f    <= '0;
      pc_d    <= '0;
      instr_d <= C_NOP;
    end else if (!stall) begin
      pc_d    <= pc_f;
      if (take) begin
        pc_f    <= target;
        instr_d <= C_NOP;
      end else begin
        pc_f    <= pc_f + DW'(ADDENT);
        instr_d <= instr_f;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      rd_m        <= '0;
      alu_m       <= '0;
      rs2_data_m  <= '0;
      link_m      <= '0;
      res_sel_m   <= RES_ALU;
    end else begin
      reg_write_m <= reg_write && !stall;
      mem_write_m <= mem_write && !stall;
      rd_m        <= rd_d;
      alu_m       <= alu_y;
      rs2_data_m  <= rs2_v;
      link_m      <= pc_d + DW'(ADDENT);
      res_sel_m   <= res_sel;
    end
  end

  riscv_reg_file #(
    .DW                  (DW),
    .REGW                (REGW),
    .NO_OF_REGS_REG_FILE (NO_OF_REGS_REG_FILE)
  ) i_reg_file (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .we_i       (reg_write_m),
    .rd_i       (rd_m),
    .wd_i       (wb_m),
    .rs1_i      (rs1_d),
    .rs2_i      (rs2_d),
    .rs1_data_o (rf_rs1),
    .rs2_data_o (rf_rs2)
  );

  // Store is suppressed on a reset edge so in-flight writes are discarded.
  riscv_data_mem #(
    .DW         (DW),
    .AW         (AW),
    .NO_OF_REGS (NO_OF_REGS)
  ) i_data_mem (
    .clk_i  (clk_i),
    .we_i   (mem_write_m && rst_i),
    .addr_i (alu_m[AW+1:2]),
    .wd_i   (rs2_data_m),
    .rd_o   (load_data)
  );
endmodule

`default_nettype wire

// File: tb/tb_riscv_pipeline_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_pipeline_core: directed self-checking bench for the core.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_riscv_pipeline_core;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  riscv_pipeline_core dut (
    .clk_i (clk_i),
    .rst_i (rst_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_t(input logic [11:0] im, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(input logic [11:0] im, input logic [4:0] rs2, input logic [4:0] rs1);
    return {im[11:5], rs2, rs1, 3'd2, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(input logic [12:0] im, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] j_t(input logic [20:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] u_t(input logic [19:0] im, input logic [4:0] rd, input logic [6:0] op);
    return {im, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] im);
    return i_t(im, rs1, 3'd0, rd, 7'h13);
  endfunction

  task automatic run(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic hold_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.instr_mem[i] = NOP;
  endtask

  task automatic chk_reg(input string name, input int idx, input logic [31:0] exp);
    checks++;
    if (dut.i_reg_file.reg_file[idx] !== exp) begin
      failures++;
      $display("FAIL %s x%0d got=%h required=%h", name, idx, dut.i_reg_file.reg_file[idx], exp);
    end
  endtask

  task automatic test_reset();
    hold_reset();
    for (int i = 0; i < 256; i++) dut.instr_mem[i] = addi(5'd1, 5'd0, 12'd5);
    rst_i = 1'b1;
    run(5);
    chk_reg("reset_pre", 1, 32'd5);
    hold_reset();
    checks++;
    if (dut.pc_d !== 32'd0) begin failures++; $display("FAIL reset_pc_d got=%h required=%h", dut.pc_d, 32'd0); end
    checks++;
    if (dut.instr_d !== NOP) begin failures++; $display("FAIL reset_instr_d got=%h required=%h", dut.instr_d, NOP); end
    checks++;
    if (dut.reg_write_m !== 1'b0 || dut.mem_write_m !== 1'b0) begin
      failures++;
      $display("FAIL reset_m_ctrl got=%b%b required=00", dut.reg_write_m, dut.mem_write_m);
    end
    begin
      int nz = 0;
      for (int r = 1; r < 32; r++) if (dut.i_reg_file.reg_file[r] !== 32'd0) nz++;
      checks++;
      if (nz != 0) begin failures++; $display("FAIL reset_regs nonzero_count got=%0d required=0", nz); end
    end
  endtask

  task automatic test_reset_midflight();
    hold_reset();
    clear_imem();
    dut.instr_mem[0] = addi(5'd1, 5'd0, 12'h011);
    dut.instr_mem[1] = s_t(12'd16, 5'd1, 5'd0);
    rst_i = 1'b1;
    run(8);
    checks++;
    if (dut.i_data_mem.data_mem[4] !== 32'h11) begin
      failures++; $display("FAIL midrst_setup got=%h required=%h", dut.i_data_mem.data_mem[4], 32'h11);
    end
    hold_reset();
    clear_imem();
    dut.instr_mem[0] = addi(5'd1, 5'd0, 12'd9);
    dut.instr_mem[3] = s_t(12'd16, 5'd1, 5'd0);
    rst_i = 1'b1;
    run(5);
    checks++;
    if (dut.mem_write_m !== 1'b1) begin failures++; $display("FAIL midrst_sw_in_m got=%b required=1", dut.mem_write_m); end
    rst_i = 1'b0;
    run(1);
    checks++;
    if (dut.i_data_mem.data_mem[4] !== 32'h11) begin
      failures++; $display("FAIL midrst_no_write got=%h required=%h", dut.i_data_mem.data_mem[4], 32'h11);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] add_i;
    add_i = r_t(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    hold_reset();
    clear_imem();
    dut.instr_mem[0] = addi(5'd1, 5'd0, 12'd2);
    dut.instr_mem[1] = add_i;
    rst_i = 1'b1;
    run(2);
    checks++;
    if (dut.instr_d !== add_i) begin failures++; $display("FAIL fwd_add_in_d got=%h required=%h", dut.instr_d, add_i); end
`ifdef RISCV_FORWARDING_EN
    checks++;
    if ({dut.forward_a, dut.forward_b} !== 2'b11) begin
      failures++; $display("FAIL fwd_flags got=%b required=11", {dut.forward_a, dut.forward_b});
    end
    run(1);
    checks++;
    if (dut.pc_d !== 32'h8) begin failures++; $display("FAIL fwd_no_stall pc_d got=%h required=%h", dut.pc_d, 32'h8); end
`else
    checks++;
    if ({dut.forward_a, dut.forward_b} !== 2'b00) begin
      failures++; $display("FAIL fwd_flags_tied got=%b required=00", {dut.forward_a, dut.forward_b});
    end
    run(1);
    checks++;
    if (dut.pc_d !== 32'h4 || dut.instr_d !== add_i || dut.reg_write_m !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold pc_d=%h instr_d=%h rw_m=%b required=00000004/%h/0", dut.pc_d, dut.instr_d, dut.reg_write_m, add_i);
    end
    run(1);
    checks++;
    if (dut.pc_d !== 32'h8) begin failures++; $display("FAIL stall_one_cycle pc_d got=%h required=%h", dut.pc_d, 32'h8); end
`endif
    run(4);
    chk_reg("fwd_x1", 1, 32'd2);
    chk_reg("fwd_x2", 2, 32'd4);
  endtask

  task automatic test_load_store();
    hold_reset();
    clear_imem();
    dut.instr_mem[0] = addi(5'd3, 5'd0, 12'd4);
    dut.instr_mem[1] = s_t(12'd8, 5'd3, 5'd0);
    dut.instr_mem[2] = i_t(12'd8, 5'd0, 3'd2, 5'd5, 7'h03);
    dut.instr_mem[3] = r_t(7'h00, 5'd5, 5'd5, 3'd0, 5'd6);
    rst_i = 1'b1;
    run(12);
    checks++;
    if (dut.i_data_mem.data_mem[2] !== 32'd4) begin
      failures++; $display("FAIL ls_mem2 got=%h required=%h", dut.i_data_mem.data_mem[2], 32'd4);
    end
    chk_reg("ls_x5", 5, 32'd4);
    chk_reg("ls_x6", 6, 32'd8);
  endtask

  task automatic test_branch_flush();
    logic [31:0] beq_i, blt_i, mark_i;
    int n;
    beq_i  = b_t(13'd8, 5'd0, 5'd3, 3'd0);
    blt_i  = b_t(13'd8, 5'd3, 5'd0, 3'd4);
    mark_i = addi(5'd8, 5'd0, 12'd9);
    hold_reset();
    clear_imem();
    dut.instr_mem[0] = addi(5'd3, 5'd0, 12'd4);
    dut.instr_mem[1] = beq_i;
    dut.instr_mem[2] = blt_i;
    dut.instr_mem[3] = addi(5'd7, 5'd0, 12'd1);
    dut.instr_mem[4] = mark_i;
    rst_i = 1'b1;
    n = 0;
    while (dut.instr_d !== beq_i && n < 10) begin run(1); n++; end
    n = 0;
    while (dut.instr_d === beq_i && n < 4) begin run(1); n++; end
    checks++;
    if (dut.instr_d !== blt_i) begin failures++; $display("FAIL br_not_taken_no_bubble got=%h required=%h", dut.instr_d, blt_i); end
    run(1);
    checks++;
    if (dut.instr_d !== NOP) begin failures++; $display("FAIL br_bubble got=%h required=%h", dut.instr_d, NOP); end
    run(1);
    checks++;
    if (dut.instr_d !== mark_i || dut.pc_d !== 32'h10) begin
      failures++; $display("FAIL br_target instr=%h pc=%h required=%h/00000010", dut.instr_d, dut.pc_d, mark_i);
    end
    run(5);
    chk_reg("br_x7", 7, 32'd0);
    chk_reg("br_x8", 8, 32'd9);
  endtask

  task automatic test_jumps();
    logic [31:0] jal_i, jalr_i;
    int n;
    jal_i  = j_t(21'd12, 5'd1);
    jalr_i = i_t(12'd0, 5'd1, 3'd0, 5'd0, 7'h67);
    hold_reset();
    clear_imem();
    dut.instr_mem[4] = jal_i;
    dut.instr_mem[5] = addi(5'd9, 5'd0, 12'd7);
    dut.instr_mem[6] = j_t(21'd12, 5'd0);
    dut.instr_mem[7] = jalr_i;
    dut.instr_mem[8] = addi(5'd10, 5'd0, 12'd1);
    dut.instr_mem[9] = addi(5'd11, 5'd0, 12'd3);
    rst_i = 1'b1;
    n = 0;
    while (dut.instr_d !== jal_i && n < 12) begin run(1); n++; end
    checks++;
    if (dut.instr_d !== jal_i || dut.pc_d !== 32'h10) begin
      failures++; $display("FAIL jal_reach instr=%h pc=%h required=%h/00000010", dut.instr_d, dut.pc_d, jal_i);
    end
    run(2);
    checks++;
    if (dut.pc_d !== 32'h1C || dut.instr_d !== jalr_i) begin
      failures++; $display("FAIL jal_target pc=%h instr=%h required=0000001c/%h", dut.pc_d, dut.instr_d, jalr_i);
    end
    run(2);
    checks++;
    if (dut.pc_d !== 32'h14) begin failures++; $display("FAIL jalr_target pc_d got=%h required=%h", dut.pc_d, 32'h14); end
    run(10);
    chk_reg("jmp_x1", 1, 32'h14);
    chk_reg("jmp_x9", 9, 32'd7);
    chk_reg("jmp_x10", 10, 32'd0);
    chk_reg("jmp_x11", 11, 32'd3);
  endtask

  task automatic test_loop();
    hold_reset();
    clear_imem();
    dut.instr_mem[0] = addi(5'd3, 5'd0, 12'd4);
    dut.instr_mem[1] = addi(5'd7, 5'd0, 12'd3);
    dut.instr_mem[2] = addi(5'd5, 5'd0, 12'd0);
    dut.instr_mem[3] = r_t(7'h00, 5'd3, 5'd4, 3'd0, 5'd4);
    dut.instr_mem[4] = addi(5'd7, 5'd7, 12'hFFF);
    dut.instr_mem[5] = b_t(13'h1FF8, 5'd5, 5'd7, 3'd1);
    dut.instr_mem[6] = addi(5'd12, 5'd0, 12'd1);
    rst_i = 1'b1;
    run(60);
    chk_reg("loop_x4", 4, 32'd12);
    chk_reg("loop_x7", 7, 32'd0);
    chk_reg("loop_x12", 12, 32'd1);
  endtask

  task automatic test_alu();
    logic [31:0] exp [32];
    hold_reset();
    clear_imem();
    dut.instr_mem[0]  = addi(5'd1, 5'd0, 12'hFF8);
    dut.instr_mem[1]  = addi(5'd2, 5'd0, 12'd3);
    dut.instr_mem[2]  = r_t(7'h20, 5'd1, 5'd2, 3'd0, 5'd3);
    dut.instr_mem[3]  = r_t(7'h20, 5'd2, 5'd1, 3'd5, 5'd4);
    dut.instr_mem[4]  = r_t(7'h00, 5'd2, 5'd1, 3'd5, 5'd5);
    dut.instr_mem[5]  = r_t(7'h00, 5'd2, 5'd1, 3'd2, 5'd6);
    dut.instr_mem[6]  = r_t(7'h00, 5'd2, 5'd1, 3'd3, 5'd7);
    dut.instr_mem[7]  = u_t(20'h12345, 5'd8, 7'h37);
    dut.instr_mem[8]  = u_t(20'h00001, 5'd9, 7'h17);
    dut.instr_mem[9]  = i_t(12'hFFF, 5'd1, 3'd4, 5'd10, 7'h13);
    dut.instr_mem[10] = i_t(12'h004, 5'd2, 3'd1, 5'd11, 7'h13);
    dut.instr_mem[11] = r_t(7'h00, 5'd2, 5'd1, 3'd7, 5'd12);
    dut.instr_mem[12] = r_t(7'h00, 5'd2, 5'd1, 3'd6, 5'd13);
    dut.instr_mem[13] = r_t(7'h00, 5'd2, 5'd2, 3'd1, 5'd14);
    dut.instr_mem[14] = i_t(12'd5, 5'd2, 3'd3, 5'd15, 7'h13);
    dut.instr_mem[15] = i_t(12'h00F, 5'd1, 3'd7, 5'd16, 7'h13);
    dut.instr_mem[16] = 32'h0000_08FF;
    dut.instr_mem[17] = i_t(12'h055, 5'd0, 3'd6, 5'd18, 7'h13);
    dut.instr_mem[18] = i_t(12'h401, 5'd1, 3'd5, 5'd19, 7'h13);
    dut.instr_mem[19] = i_t(12'h01C, 5'd1, 3'd5, 5'd20, 7'h13);
    dut.instr_mem[20] = i_t(12'hFF9, 5'd1, 3'd2, 5'd21, 7'h13);
    dut.instr_mem[21] = b_t(13'd8, 5'd2, 5'd1, 3'd7);
    dut.instr_mem[22] = addi(5'd22, 5'd0, 12'd1);
    dut.instr_mem[23] = b_t(13'd8, 5'd2, 5'd1, 3'd5);
    dut.instr_mem[24] = addi(5'd23, 5'd0, 12'd1);
    dut.instr_mem[25] = r_t(7'h00, 5'd2, 5'd1, 3'd4, 5'd24);
    exp = '{default: 32'd0};
    exp[1]  = 32'hFFFF_FFF8; exp[2]  = 32'd3;        exp[3]  = 32'd11;
    exp[4]  = 32'hFFFF_FFFF; exp[5]  = 32'h1FFF_FFFF; exp[6] = 32'd1;
    exp[7]  = 32'd0;         exp[8]  = 32'h1234_5000; exp[9] = 32'h0000_1020;
    exp[10] = 32'd7;         exp[11] = 32'd48;        exp[12] = 32'd0;
    exp[13] = 32'hFFFF_FFFB; exp[14] = 32'd24;        exp[15] = 32'd1;
    exp[16] = 32'd8;         exp[17] = 32'd0;         exp[18] = 32'h55;
    exp[19] = 32'hFFFF_FFFC; exp[20] = 32'hF;         exp[21] = 32'd1;
    exp[22] = 32'd0;         exp[23] = 32'd1;         exp[24] = 32'hFFFF_FFFB;
    rst_i = 1'b1;
    run(60);
    for (int r = 1; r < 25; r++) chk_reg("alu", r, exp[r]);
  endtask

  initial begin
    test_reset();
    test_reset_midflight();
    test_forwarding();
    test_load_store();
    test_branch_flush();
    test_jumps();
    test_loop();
    test_alu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
